// File: rtl/display_7seg_2dig_if.sv
// Digit bus from the 0-99 counter: units (M) and tens (S) BCD digits.
// The counter drives it as master; the display consumes it as slave.
interface display_7seg_2dig_if;
    logic [3:0] M;
    logic [3:0] S;

    modport master (output M, output S);
    modport slave  (input  M, input  S);
endinterface

// File: rtl/display_7seg_2dig.sv
// Two-digit multiplexed 7-segment driver: latches the digit bus once per scan frame,
// decodes BCD, and applies leading-zero blanking, blinking and invalid-digit flagging.
module display_7seg_2dig #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 100,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    display_7seg_2dig_if.slave   digits,
    input  logic                 blank_lz,
    input  logic                 blink_en,
    output logic [6:0]           seg,
    output logic [1:0]           an,
    output logic                 bcd_err
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] SEG_INV = ACTIVE_LOW ? 7'h7f : 7'h00;
    localparam logic [1:0] AN_INV  = ACTIVE_LOW ? 2'b11 : 2'b00;

    typedef enum logic {SLOT_UNITS = 1'b0, SLOT_TENS = 1'b1} slot_t;

    logic [PW-1:0] presc;
    slot_t         slot;
    logic [3:0]    units;
    logic [3:0]    tens;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    logic          tick;
    logic          frame_end;
    logic [6:0]    seg_act;
    logic [1:0]    an_act;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    assign tick      = (presc == PW'(SCAN_DIV - 1));
    assign frame_end = tick && (slot == SLOT_TENS);

    // Active-high view of the selected slot; blinking overrides leading-zero blanking.
    always_comb begin
        seg_act = decode((slot == SLOT_TENS) ? tens : units);
        an_act  = (slot == SLOT_TENS) ? 2'b10 : 2'b01;
        if (slot == SLOT_TENS && blank_lz && tens == 4'd0) begin
            seg_act = 7'b0000000;
            an_act  = 2'b00;
        end
        if (blink_en && blink_phase) begin
            seg_act = 7'b0000000;
            an_act  = 2'b00;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            slot        <= SLOT_UNITS;
            units       <= 4'd0;
            tens        <= 4'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= SEG_INV;
            an          <= AN_INV;
            bcd_err     <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                slot <= (slot == SLOT_TENS) ? SLOT_UNITS : SLOT_TENS;
            end
            // Both digits change together so a frame never mixes old and new values.
            if (frame_end) begin
                units <= digits.M;
                tens  <= digits.S;
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
            seg     <= seg_act ^ SEG_INV;
            an      <= an_act ^ AN_INV;
            bcd_err <= (units > 4'd9) || (tens > 4'd9);
        end
    end

endmodule

// File: doc/display_7seg_2dig.md
Name: display_7seg_2dig

Overview:
- Consumer end of the two-digit BCD counter bus. Takes the units digit (M) and tens digit (S) and drives a time-multiplexed two-digit 7-segment display.
- Latches both digits once per scan frame so a frame never shows a mixed value, decodes BCD to segments, and supports leading-zero blanking, whole-display blinking and invalid-BCD flagging.
- Sits between the 0–99 counter and the board display pins.

Parameters:
- SCAN_DIV, 50000: clocks per digit slot; minimum 2.
- BLINK_FRAMES, 100: full frames (units slot plus tens slot) per blink half-period; minimum 1.
- ACTIVE_LOW, 1: 1 means segment and digit-enable outputs are active-low (common anode); 0 means active-high.

Ports:
- clock, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high; clears all state.
- M, in, 4: units BCD digit from the counter (M[3] is the MSB).
- S, in, 4: tens BCD digit from the counter.
- blank_lz, in, 1: 1 blanks the tens digit when the latched tens value is 0.
- blink_en, in, 1: 1 enables whole-display blinking.
- seg, out, 7: segment pattern {g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW.
- an, out, 2: digit enables; an[0] is units, an[1] is tens; polarity set by ACTIVE_LOW.
- bcd_err, out, 1: 1 while either latched digit is greater than 9.

Behaviour:
- Reset, asynchronous:
  - State: prescaler = 0, digit_sel = 0 (units), latched units = 0, latched tens = 0, frame counter = 0, blink_phase = 0.
  - Outputs: seg all inactive, an both inactive, bcd_err = 0.
  - Reset asserted mid-scan forces these values immediately, without waiting for a clock edge.
- Prescaler:
  - Counts 0 to SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
  - On each tick edge, digit_sel toggles.
- Frame boundary: a tick while digit_sel = 1, so digit_sel goes 1→0. On that edge:
  - Latch M into the units register and S into the tens register.
  - Increment the frame counter. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - M/S changes between frame boundaries have no effect on the display.
- Decode, internal active-high pattern, before polarity:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - 10–15 = 1000000 (dash, segment g only).
- Output stage, registered, updated every clock from current state (one-clock latency after a digit_sel or latch change):
  - an: the enable for the digit selected by digit_sel is active; the other is inactive.
  - seg: decode of the selected latched digit.
  - Blank condition, all segments and both an inactive: blink_en = 1 and blink_phase = 1.
  - Tens-only blank: blank_lz = 1, digit_sel = 1 and latched tens = 0. Tens an and seg are inactive; the units slot is unaffected. The units digit is never blanked, so 00 shows as " 0".
  - bcd_err = (latched units > 9) or (latched tens > 9), registered. It is not masked by blanking or blinking.
- Blink control:
  - The frame counter and blink_phase run continuously, regardless of blink_en.
  - Deasserting blink_en restores the display on the next clock.
- Polarity: when ACTIVE_LOW = 1, seg and an are the inversion of the active-high values. The inactive level is therefore all 1s.
- Simultaneous events:
  - A frame-boundary latch and a blink wrap on the same edge both take effect.
  - The output on the following clock reflects the new digits and the new phase.
- Implementation: synchronous to clock only; no gated or derived clocks.

Test Plan:
1. Reset check: assert reset with SCAN_DIV=4, ACTIVE_LOW=1.
   - During reset: seg=1111111, an=11, bcd_err=0.
   - After release: an=10 (units slot), seg=1000000 (digit "0", active-low).
2. Scan and latch: SCAN_DIV=4, M=3, S=7 held from reset.
   - an alternates 10/01 every 4 clocks.
   - The first frame shows 0/0. After the first frame boundary, the units slot shows seg=0110000 and the tens slot seg=1111000.
3. Tear-free latch: change M 3→8 while the tens slot is active.
   - The units slot stays 3 until the next frame boundary, then shows 8 (seg=0000000).
4. Leading-zero blanking: blank_lz=1, S=0, M=5.
   - Tens slot has an=11 and seg=1111111.
   - Units slot shows seg=0010010.
   - With S=2, the tens slot shows 0100100.
5. Blink: BLINK_FRAMES=2, blink_en=1.
   - Display is dark for 2 frames, then on for 2 frames, repeating.
   - Clearing blink_en while dark restores output within 1 clock.
6. Invalid BCD and async reset: drive M=12.
   - After latch: units seg=0111111 (dash) and bcd_err=1.
   - Assert reset mid-slot between clock edges: outputs are inactive immediately and bcd_err=0.
